led_pio_write_arbiter: RTL

Round-robin arbiter and bus sequencer that shares the 8-bit LED PIO Avalon-MM slave among several on-chip requesters, such as game-state logic, score display and debug. It sits between the requesters and the PIO slave port. It issues single-cycle write transactions to PIO register 0 on the winners' behalf. It keeps a shadow of the last value written and, optionally, reads the register back to verify each write.

---
 rtl/led_pio_write_arbiter_if.sv | 31 +++
 rtl/led_pio_write_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/led_pio_write_arbiter_if.sv
// led_pio_write_arbiter_if: requester-side handshake plus LED PIO Avalon-MM
// signals for led_pio_write_arbiter. The arbiter connects through the master
// modport; the requesters and the PIO slave model use the slave modport.
interface led_pio_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic [7:0]           led_shadow;
  logic                 err;
  logic                 err_clr;
  logic [1:0]           avm_address;
  logic                 avm_chipselect;
  logic                 avm_write_n;
  logic [31:0]          avm_writedata;
  logic [31:0]          avm_readdata;

  modport master (
    input  req, req_data, err_clr, avm_readdata,
    output ack, busy, led_shadow, err,
    output avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  modport slave (
    output req, req_data, err_clr, avm_readdata,
    input  ack, busy, led_shadow, err,
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/led_pio_write_arbiter.sv
// led_pio_write_arbiter: round-robin arbiter that shares the 8-bit LED PIO
// among NUM_REQ requesters, issuing one write to PIO register 0 per grant and
// keeping a shadow of the last value written.
// Build option: define LED_ARB_READBACK_EN to add a READ state that reads the
// register back after each write and raises a sticky err on mismatch.
// All avm_* and handshake outputs are decoded from registered state only.
module led_pio_write_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  led_pio_write_arbiter_if.master bus
);
  localparam int                 IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [NUM_REQ-1:0] ACK_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic [7:0]       shadow_q, shadow_d;

  logic             arb_found_s;
  logic [IDX_W-1:0] arb_idx_s;
  int               cand_sum_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             cand_hit_s;

  // Round-robin search: first set req at or above rr_ptr, wrapping to 0
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    cand_sum_s  = 0;
    cand_idx_s  = '0;
    cand_hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_s  = int'(rr_ptr_q) + k;
      cand_sum_s  = (cand_sum_s >= NUM_REQ) ? (cand_sum_s - NUM_REQ) : cand_sum_s;
      cand_idx_s  = IDX_W'(cand_sum_s);
      cand_hit_s  = !arb_found_s && bus.req[cand_idx_s];
      arb_idx_s   = cand_hit_s ? cand_idx_s : arb_idx_s;
      arb_found_s = arb_found_s | cand_hit_s;
    end
  end

  // Sequencer next state; requests are only looked at in IDLE, the winner's
  // data is captured in GRANT so later changes on req/req_data are ignored
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_idx_d   = win_idx_q;
    hold_data_d = hold_data_q;
    shadow_d    = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found_s) begin
          state_d   = ST_GRANT;
          win_idx_d = arb_idx_s;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_d     = ST_WRITE;
        hold_data_d = bus.req_data[{win_idx_q, 3'b000} +: 8];
        rr_ptr_d    = (win_idx_q == IDX_LAST) ? '0 : (win_idx_q + IDX_ONE);
      end
      ST_WRITE: begin
        shadow_d = hold_data_q;
`ifdef LED_ARB_READBACK_EN
        state_d  = ST_READ;
`else
        state_d  = ST_DONE;
`endif
      end
      ST_READ:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      win_idx_q   <= '0;
      hold_data_q <= 8'h00;
      shadow_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_idx_q   <= win_idx_d;
      hold_data_q <= hold_data_d;
      shadow_q    <= shadow_d;
    end
  end

  // Bus strobes and ack decoded purely from the state register
  always_comb begin
    bus.avm_address    = 2'b00;
    bus.avm_chipselect = 1'b0;
    bus.avm_write_n    = 1'b1;
    bus.avm_writedata  = 32'h0000_0000;
    bus.ack            = '0;
    bus.busy           = (state_q != ST_IDLE);
    case (state_q)
      ST_WRITE: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_write_n    = 1'b0;
        bus.avm_writedata  = {24'h00_0000, hold_data_q};
      end
      ST_READ:  bus.avm_chipselect = 1'b1;
      ST_DONE:  bus.ack = ACK_LSB << win_idx_q;
      default:  bus.avm_chipselect = 1'b0;
    endcase
  end

  assign bus.led_shadow = shadow_q;

`ifdef LED_ARB_READBACK_EN
  logic err_q, err_d, rb_mismatch_s;
  logic unused_ok_s;

  // Sticky readback error; a mismatch in the same cycle outranks err_clr
  always_comb begin
    rb_mismatch_s = (state_q == ST_READ) && (bus.avm_readdata[7:0] != hold_data_q);
    if (rb_mismatch_s) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err     = err_q;
  assign unused_ok_s = ^bus.avm_readdata[31:8];
`else
  logic unused_ok_s;

  assign bus.err     = 1'b0;
  assign unused_ok_s = ^{bus.err_clr, bus.avm_readdata};
`endif
endmodule
